// File: rtl/boot_loader.sv
// Host-side loader: parses a byte stream into IMEM/DMEM write packets and
// holds the DSP core in reset until a RUN command releases it.
module boot_loader #(
  parameter int INST_ADDR_LEN = 16,
  parameter int INST_WORD_LEN = 32,
  parameter int MEM_ADDR_LEN  = 15,
  parameter int REG_WORD_LEN  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [INST_ADDR_LEN-1:0] write_addr_i,
  output logic [INST_WORD_LEN-1:0] write_data_i,
  output logic                     write_en_i,
  output logic [MEM_ADDR_LEN-1:0]  write_addr_1,
  output logic [REG_WORD_LEN-1:0]  write_data_1,
  output logic                     write_en_1,
  output logic                     dsp_rst,
  output logic                     done,
  output logic                     error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L, S_DATA, S_WRITE, S_RUN
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic                     r_started;
  logic                     r_isImem;
  logic [INST_ADDR_LEN-1:0] r_addr;
  logic [15:0]              r_count;
  logic [INST_WORD_LEN-9:0] r_word;
  logic [1:0]               r_byteIdx;
  logic [INST_ADDR_LEN-1:0] r_waddrI;
  logic [INST_WORD_LEN-1:0] r_wdataI;
  logic                     r_wenI;
  logic [MEM_ADDR_LEN-1:0]  r_waddr1;
  logic [REG_WORD_LEN-1:0]  r_wdata1;
  logic                     r_wen1;
  logic                     r_error;

  logic                     w_accept;
  logic                     w_lastByte;
  logic                     w_cmdMem;
  logic [15:0]              w_cntNext;

  // r_started delays in_ready by one edge after reset release.
  assign in_ready   = r_started && (r_state != S_WRITE) && (r_state != S_RUN);
  assign w_accept   = in_valid && in_ready;
  assign w_lastByte = r_isImem ? (r_byteIdx == 2'd3) : (r_byteIdx == 2'd1);
  assign w_cmdMem   = (in_data == 8'h01) || (in_data == 8'h02);
  assign w_cntNext  = {r_count[15:8], in_data};

  assign write_addr_i = r_waddrI;
  assign write_data_i = r_wdataI;
  assign write_en_i   = r_wenI;
  assign write_addr_1 = r_waddr1;
  assign write_data_1 = r_wdata1;
  assign write_en_1   = r_wen1;
  assign dsp_rst      = (r_state != S_RUN);
  assign done         = (r_state == S_RUN);
  assign error        = r_error;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cmdMem)               w_next = S_ADDR_H;
          else if (in_data == 8'h03)  w_next = S_RUN;
        end
      end
      S_ADDR_H: if (w_accept) w_next = S_ADDR_L;
      S_ADDR_L: if (w_accept) w_next = S_CNT_H;
      S_CNT_H:  if (w_accept) w_next = S_CNT_L;
      S_CNT_L:  if (w_accept) w_next = (w_cntNext == 16'd0) ? S_IDLE : S_DATA;
      S_DATA:   if (w_accept && w_lastByte) w_next = S_WRITE;
      S_WRITE:  w_next = (r_count == 16'd1) ? S_IDLE : S_DATA;
      S_RUN:    w_next = S_RUN;
      default:  w_next = S_IDLE;
    endcase
  end

  // Strobes are one-cycle pulses launched on the edge that takes the last
  // byte, so they line up exactly with the WRITE state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_started <= 1'b0;
      r_isImem  <= 1'b0;
      r_addr    <= '0;
      r_count   <= '0;
      r_word    <= '0;
      r_byteIdx <= '0;
      r_waddrI  <= '0;
      r_wdataI  <= '0;
      r_wenI    <= 1'b0;
      r_waddr1  <= '0;
      r_wdata1  <= '0;
      r_wen1    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_started <= 1'b1;
      r_wenI    <= 1'b0;
      r_wen1    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_cmdMem)              r_isImem <= (in_data == 8'h01);
            else if (in_data != 8'h03) r_error  <= 1'b1;
          end
        end
        S_ADDR_H: if (w_accept) r_addr[15:8]  <= in_data;
        S_ADDR_L: if (w_accept) r_addr[7:0]   <= in_data;
        S_CNT_H:  if (w_accept) r_count[15:8] <= in_data;
        S_CNT_L: begin
          if (w_accept) begin
            r_count[7:0] <= in_data;
            r_byteIdx    <= 2'd0;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_word    <= {r_word[INST_WORD_LEN-17:0], in_data};
            r_byteIdx <= r_byteIdx + 2'd1;
            if (w_lastByte) begin
              if (r_isImem) begin
                r_wenI   <= 1'b1;
                r_waddrI <= r_addr;
                r_wdataI <= {r_word, in_data};
              end else begin
                r_wen1   <= 1'b1;
                r_waddr1 <= r_addr[MEM_ADDR_LEN-1:0];
                r_wdata1 <= {r_word[REG_WORD_LEN-9:0], in_data};
              end
            end
          end
        end
        S_WRITE: begin
          r_addr    <= r_addr + 1'b1;
          r_count   <= r_count - 16'd1;
          r_byteIdx <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: table vectors, randomized packets
// against a stream-level parser model, and hand-written reset/RUN sequences.
module tb_boot_loader;

  typedef logic [7:0] byteQ_t[$];

  typedef struct packed {
    logic        isImem;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [127:0] bytes;
    int           len;
    int           nWr;
    logic         isImem;
    logic [15:0]  a0;
    logic [31:0]  d0;
    logic [15:0]  a1;
    logic [31:0]  d1;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] write_addr_i;
  logic [31:0] write_data_i;
  logic        write_en_i;
  logic [14:0] write_addr_1;
  logic [15:0] write_data_1;
  logic        write_en_1;
  logic        dsp_rst;
  logic        done;
  logic        error;

  int  testsRun = 0;
  int  testsFailed = 0;
  wr_t gotQ[$];
  wr_t expQ[$];
  bit  expRun = 0;
  bit  expErr = 0;

  boot_loader dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .write_addr_i(write_addr_i),
    .write_data_i(write_data_i), .write_en_i(write_en_i),
    .write_addr_1(write_addr_1), .write_data_1(write_data_1),
    .write_en_1(write_en_1), .dsp_rst(dsp_rst), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture every strobe; sampled on the falling edge, away from updates.
  always @(negedge clk) begin
    wr_t w;
    if (write_en_i || write_en_1) begin
      checkOutput("strobeExclusive", {31'd0, write_en_i && write_en_1}, 32'd0);
      checkOutput("readyLowOnWrite", {31'd0, in_ready}, 32'd0);
      if (write_en_i) begin
        w.isImem = 1'b1; w.addr = write_addr_i; w.data = write_data_i;
      end else begin
        w.isImem = 1'b0; w.addr = {1'b0, write_addr_1}; w.data = {16'd0, write_data_1};
      end
      gotQ.push_back(w);
    end
  end

  // Reference: walk the byte stream packet by packet and list the writes.
  task automatic modelStream(input byteQ_t s);
    int i = 0;
    logic [7:0]  cmd;
    logic [15:0] addr, cnt;
    logic [31:0] data;
    wr_t w;
    while (i < s.size() && !expRun) begin
      cmd = s[i]; i++;
      if (cmd == 8'h01 || cmd == 8'h02) begin
        addr = {s[i], s[i+1]};
        cnt  = {s[i+2], s[i+3]};
        i += 4;
        for (int k = 0; k < int'(cnt); k++) begin
          data = 0;
          for (int b = 0; b < ((cmd == 8'h01) ? 4 : 2); b++) begin
            data = (data << 8) | {24'd0, s[i]};
            i++;
          end
          w.isImem = (cmd == 8'h01);
          w.addr   = (cmd == 8'h01) ? addr : (addr % 16'h8000);
          w.data   = data;
          expQ.push_back(w);
          addr = addr + 16'd1;
        end
      end else if (cmd == 8'h03) begin
        expRun = 1;
      end else begin
        expErr = 1;
      end
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the byte is taken.
  task automatic sendByte(input logic [7:0] b, input bit bubbles);
    int guard = 0;
    if (bubbles) begin
      for (int n = 0; n < 5 && $urandom_range(0, 99) < 40; n++) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checkOutput("handshakeTimeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input byteQ_t s, input bit bubbles);
    foreach (s[k]) sendByte(s[k], bubbles);
    repeat (4) @(negedge clk);
  endtask

  task automatic compareWrites(input string tag);
    checkOutput($sformatf("%s.count", tag), gotQ.size(), expQ.size());
    for (int k = 0; k < gotQ.size() && k < expQ.size(); k++) begin
      checkOutput($sformatf("%s.kind%0d", tag, k), {31'd0, gotQ[k].isImem}, {31'd0, expQ[k].isImem});
      checkOutput($sformatf("%s.addr%0d", tag, k), {16'd0, gotQ[k].addr}, {16'd0, expQ[k].addr});
      checkOutput($sformatf("%s.data%0d", tag, k), gotQ[k].data, expQ[k].data);
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".in_ready"}, {31'd0, in_ready}, 32'd0);
    checkOutput({tag, ".write_en_i"}, {31'd0, write_en_i}, 32'd0);
    checkOutput({tag, ".write_en_1"}, {31'd0, write_en_1}, 32'd0);
    checkOutput({tag, ".write_addr_i"}, {16'd0, write_addr_i}, 32'd0);
    checkOutput({tag, ".write_data_i"}, write_data_i, 32'd0);
    checkOutput({tag, ".write_addr_1"}, {17'd0, write_addr_1}, 32'd0);
    checkOutput({tag, ".write_data_1"}, {16'd0, write_data_1}, 32'd0);
    checkOutput({tag, ".dsp_rst"}, {31'd0, dsp_rst}, 32'd1);
    checkOutput({tag, ".done"}, {31'd0, done}, 32'd0);
    checkOutput({tag, ".error"}, {31'd0, error}, 32'd0);
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b1;
    #1 checkOutput("readyLowBeforeEdge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 checkOutput("readyHighAfterEdge", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    vec_t   vecs[4];
    byteQ_t s;
    logic [15:0] addr;
    int     cnt;
    bit     imem;

    vecs[0] = '{128'h01_00_00_00_01_D0_1F_00_F5 << 56, 9, 1, 1'b1,
                16'h0000, 32'hD01F00F5, 16'h0000, 32'h0};
    vecs[1] = '{128'h02_00_00_00_02_00_19_00_2A << 56, 9, 2, 1'b0,
                16'h0000, 32'd25, 16'h0001, 32'd42};
    vecs[2] = '{128'h01_FF_FF_00_02_11_22_33_44_55_66_77_88 << 24, 13, 2, 1'b1,
                16'hFFFF, 32'h11223344, 16'h0000, 32'h55667788};
    vecs[3] = '{128'h02_FF_FF_00_01_00_07 << 72, 7, 1, 1'b0,
                16'h7FFF, 32'd7, 16'h0000, 32'h0};

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    #2 rst = 1'b0;
    #1 checkResetValues("reset");
    releaseReset();

    foreach (vecs[v]) begin
      s.delete();
      for (int k = 0; k < vecs[v].len; k++) s.push_back(vecs[v].bytes[127 - 8*k -: 8]);
      applyStimulus(s, 0);
      checkOutput($sformatf("vec%0d.count", v), gotQ.size(), vecs[v].nWr);
      if (gotQ.size() >= 1) begin
        checkOutput($sformatf("vec%0d.kind0", v), {31'd0, gotQ[0].isImem}, {31'd0, vecs[v].isImem});
        checkOutput($sformatf("vec%0d.addr0", v), {16'd0, gotQ[0].addr}, {16'd0, vecs[v].a0});
        checkOutput($sformatf("vec%0d.data0", v), gotQ[0].data, vecs[v].d0);
      end
      if (gotQ.size() >= 2) begin
        checkOutput($sformatf("vec%0d.kind1", v), {31'd0, gotQ[1].isImem}, {31'd0, vecs[v].isImem});
        checkOutput($sformatf("vec%0d.addr1", v), {16'd0, gotQ[1].addr}, {16'd0, vecs[v].a1});
        checkOutput($sformatf("vec%0d.data1", v), gotQ[1].data, vecs[v].d1);
      end
      if (vecs[v].isImem)
        checkOutput($sformatf("vec%0d.heldData", v), write_data_i, (vecs[v].nWr == 2) ? vecs[v].d1 : vecs[v].d0);
      else
        checkOutput($sformatf("vec%0d.heldData", v), {16'd0, write_data_1}, (vecs[v].nWr == 2) ? vecs[v].d1 : vecs[v].d0);
      checkOutput($sformatf("vec%0d.dspRst", v), {31'd0, dsp_rst}, 32'd1);
      gotQ.delete();
    end

    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hD0, 8'h1F, 8'h00, 8'hF5};
    modelStream(s);
    applyStimulus(s, 1);
    compareWrites("bubbleImem");

    for (int p = 0; p < 8; p++) begin
      imem = 1'($urandom);
      case ($urandom_range(0, 3))
        0: addr = 16'hFFFE;
        1: addr = 16'h7FFE;
        2: addr = 16'hFFFF;
        default: addr = 16'($urandom);
      endcase
      cnt = $urandom_range(1, 4);
      s = '{imem ? 8'h01 : 8'h02, addr[15:8], addr[7:0], 8'h00, 8'(cnt)};
      for (int k = 0; k < cnt * (imem ? 4 : 2); k++) s.push_back(8'($urandom));
      modelStream(s);
      applyStimulus(s, 1);
      compareWrites($sformatf("rand%0d", p));
    end

    checkOutput("errorClear", {31'd0, error}, 32'd0);
    s = '{8'h55};
    applyStimulus(s, 0);
    checkOutput("errorSet", {31'd0, error}, 32'd1);
    s = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00};
    applyStimulus(s, 0);
    checkOutput("zeroCount.count", gotQ.size(), 0);
    checkOutput("errorSticky", {31'd0, error}, 32'd1);
    s = '{8'h03};
    applyStimulus(s, 0);
    checkOutput("run.dsp_rst", {31'd0, dsp_rst}, 32'd0);
    checkOutput("run.done", {31'd0, done}, 32'd1);
    checkOutput("run.in_ready", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_data  = (k % 2 == 0) ? 8'h01 : 8'h00;
      @(negedge clk);
      checkOutput("run.ignoreReady", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    checkOutput("run.noWrites", gotQ.size(), 0);
    checkOutput("run.doneHeld", {31'd0, done}, 32'd1);

    #2 rst = 1'b0;
    #1 checkResetValues("runReset");
    releaseReset();

    gotQ.delete();
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hAA, 8'hBB};
    foreach (s[k]) sendByte(s[k], 0);
    #2 rst = 1'b0;
    #1 checkResetValues("midReset");
    repeat (3) @(negedge clk);
    checkOutput("midReset.noStrobe", gotQ.size(), 0);
    releaseReset();

    expRun = 0;
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'hD0, 8'h1F, 8'h00, 8'hF5};
    modelStream(s);
    applyStimulus(s, 0);
    compareWrites("restart");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/boot_loader.md
Name: boot_loader

Overview:
- Host-side writer for the DSP memory banks.
- Accepts a byte stream over a valid/ready handshake and assembles packets into words.
- Writes instruction SRAM through write_addr_i/write_data_i/write_en_i and data bank 1 through write_addr_1/write_data_1/write_en_1, holding the DSP in reset throughout.
- On a RUN command it releases DSP reset so the core fetches from instruction address 0.

Parameters:
- INST_ADDR_LEN, 16, instruction SRAM address width
- INST_WORD_LEN, 32, instruction word width (4 bytes)
- MEM_ADDR_LEN, 15, data SRAM address width
- REG_WORD_LEN, 16, data word width (2 bytes)

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset
- in_data  input  8  stream byte
- in_valid  input  1  in_data valid
- in_ready  output  1  loader accepts byte this cycle
- write_addr_i  output  INST_ADDR_LEN  instruction SRAM write address
- write_data_i  output  INST_WORD_LEN  instruction SRAM write data
- write_en_i  output  1  instruction SRAM write strobe
- write_addr_1  output  MEM_ADDR_LEN  data bank 1 write address
- write_data_1  output  REG_WORD_LEN  data bank 1 write data
- write_en_1  output  1  data bank 1 write strobe
- dsp_rst  output  1  active-high reset to DSP core
- done  output  1  DSP released
- error  output  1  sticky bad-command flag

Behaviour:
- Reset (rst=0, async) values:
  - state=IDLE, in_ready=0, all write_* = 0, dsp_rst=1, done=0, error=0.
  - in_ready rises the first clk edge after rst deasserts.
- Handshake: a byte is consumed only on an edge where in_valid && in_ready.
- Packet format, all fields big-endian:
  - CMD byte.
  - CMD 0x01 (IMEM) and 0x02 (DMEM): ADDR (2 bytes), COUNT (2 bytes, in words), then COUNT words. Each IMEM word is 4 bytes; each DMEM word is 2 bytes.
  - CMD 0x03 (RUN): no payload.
- States:
  - IDLE: accept CMD. 0x01/0x02 -> ADDR_H. 0x03 -> RUN. Any other value -> set error, stay in IDLE, byte discarded.
  - ADDR_H, ADDR_L, CNT_H, CNT_L: one byte each, latched into addr/count registers.
  - After CNT_L: COUNT == 0 -> IDLE with no writes; otherwise -> DATA.
  - DATA: shift bytes into the word assembly register (MSB first). The final byte of a word -> WRITE.
  - WRITE: exactly one cycle.
    - Drive write_en_i (IMEM) or write_en_1 (DMEM) high, with address = addr register and data = assembled word.
    - in_ready=0 during this cycle.
    - Then addr+1 and count-1. count reaches 0 -> IDLE, else -> DATA.
  - RUN: dsp_rst=0, done=1, in_ready=0, permanently until rst asserts.
- Write strobes are registered single-cycle pulses. Address and data are stable during the strobe cycle and hold their values afterwards.
- Address width rules:
  - IMEM address wraps modulo 2^16 (0xFFFF+1 -> 0x0000).
  - DMEM uses ADDR[14:0]; ADDR[15] is ignored; wraps 0x7FFF -> 0x0000.
- Throughput:
  - IMEM word: minimum 5 cycles (4 bytes + WRITE).
  - DMEM word: minimum 3 cycles.
- Bubbles: in_valid low mid-word stalls state with no timeout; partial word bytes are retained.
- write_en_i and write_en_1 are never high in the same cycle.
- error is sticky until reset and does not block subsequent valid packets.
- rst asserted mid-packet: the partial packet is discarded, no strobe is issued, and dsp_rst returns to 1 immediately (async).

Test Plan:
- Reset then stream 01 00 00 00 01 D0 1F 00 F5 -> single write_en_i pulse with write_addr_i=0x0000 and write_data_i=0xD01F00F5; in_ready low that cycle; dsp_rst still 1.
- Stream 02 00 00 00 02 00 19 00 2A -> two write_en_1 pulses: (addr 0, data 25) then (addr 1, data 42); no write_en_i activity.
- Stream 01 FF FF 00 02 followed by two 4-byte words -> writes at 0xFFFF then 0x0000. Stream 02 FF FF 00 01 00 07 -> write_addr_1=0x7FFF, data 7.
- Stream 55 then 01 00 10 00 00 then 03 -> error=1 after 0x55; zero-count packet causes no writes; RUN gives dsp_rst=0, done=1, in_ready=0; later bytes are ignored.
- Toggle in_valid randomly during an IMEM packet -> same write address/data as the back-to-back case. Assert rst after 2 data bytes -> no strobe, all outputs return to reset values asynchronously.
